// File: rtl/ctrl_seq.sv
// ctrl_seq: sequencing control unit for the 9-bit core.
// Decodes the instruction word from instr ROM and drives the reg_file
// addresses/enable, ALU op, data_memory write enable, write-source mux and
// the PC controls. Owns an IDLE/RUN/LOAD_WAIT/DONE state machine, a
// registered equal flag for conditional jumps and a multi-cycle load stall.
//
// Ports:
//   Clk, Reset          clock, asynchronous active-high reset
//   Start               one-cycle pulse that begins a program
//   Instruction[8:0]    machine code from instr ROM
//   Zero                ALU zero flag for the current cycle
//   Stall               PC hold
//   Done                program finished (registered)
//   RegWrEn, MemWrEn    reg_file / data_memory write enables
//   ReadRegAddrA/B      reg_file read addresses
//   WriteRegAddr        reg_file write address
//   ALUOp               ALU operation code
//   WriteSource         00 ALU, 01 data_mem, 10 lLUT, 11 mLUT
//   JumpTaken           PC loads the jump target
//   JumpTarget          index into the jump LUT
module ctrl_seq #(
  parameter int unsigned MEM_LAT   = 1,
  parameter logic [2:0]  SHAMT_REG = 3'b100,
  parameter int unsigned TGT_W     = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [8:0]       Instruction,
  input  logic             Zero,
  output logic             Stall,
  output logic             Done,
  output logic             RegWrEn,
  output logic             MemWrEn,
  output logic [2:0]       ReadRegAddrA,
  output logic [2:0]       ReadRegAddrB,
  output logic [2:0]       WriteRegAddr,
  output logic [2:0]       ALUOp,
  output logic [1:0]       WriteSource,
  output logic             JumpTaken,
  output logic [TGT_W-1:0] JumpTarget
);

  // ALU operation codes shared with the datapath
  localparam logic [2:0] kLSH = 3'd1;
  localparam logic [2:0] kRSH = 3'd2;
  localparam logic [2:0] kXOR = 3'd3;
  localparam logic [2:0] kRXR = 3'd4;
  localparam logic [2:0] kORR = 3'd5;

  // A zero-latency memory lets LDR retire in its own cycle
  localparam logic       LOAD_1CYC = (MEM_LAT == 0);
  localparam logic [2:0] CNT_INIT  = LOAD_1CYC ? 3'd0 : 3'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUN       = 2'd1,
    S_LOAD_WAIT = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t     state_r;
  logic       eq_flag_r;
  logic       done_r;
  logic [2:0] cnt_r;

  logic       ldr_issue_s;
  logic       cmp_s;
  logic       ack_s;

  assign Done = done_r;

  // Instruction decode and per-state output selection
  always_comb begin
    Stall        = 1'b1;
    RegWrEn      = 1'b0;
    MemWrEn      = 1'b0;
    ReadRegAddrA = 3'd0;
    ReadRegAddrB = 3'd0;
    WriteRegAddr = 3'd0;
    ALUOp        = 3'd0;
    WriteSource  = 2'b00;
    JumpTaken    = 1'b0;
    JumpTarget   = '0;
    ldr_issue_s  = 1'b0;
    cmp_s        = 1'b0;
    ack_s        = 1'b0;
    case (state_r)
      S_RUN: begin
        Stall = 1'b0;
        casez (Instruction)
          9'b000??????: begin
            WriteRegAddr = Instruction[5:3];
            ReadRegAddrA = SHAMT_REG;
            ReadRegAddrB = Instruction[2:0];
            ALUOp        = kLSH;
            RegWrEn      = 1'b1;
          end
          9'b001??????: begin
            WriteRegAddr = Instruction[5:3];
            ReadRegAddrA = SHAMT_REG;
            ReadRegAddrB = Instruction[2:0];
            ALUOp        = kRSH;
            RegWrEn      = 1'b1;
          end
          9'b0110?????: begin
            WriteRegAddr = Instruction[4:2];
            ReadRegAddrA = Instruction[4:2];
            ReadRegAddrB = SHAMT_REG;
            ALUOp        = kXOR;
            RegWrEn      = 1'b1;
          end
          9'b0111?????: begin
            WriteRegAddr = Instruction[4:2];
            ReadRegAddrA = Instruction[4:2];
            ALUOp        = kRXR;
            RegWrEn      = 1'b1;
          end
          9'b1101?????: begin
            WriteRegAddr = Instruction[4:2];
            ReadRegAddrA = Instruction[4:2];
            ReadRegAddrB = {1'b1, Instruction[1:0]};
            ALUOp        = kORR;
            RegWrEn      = 1'b1;
          end
          9'b1100?????: begin
            WriteRegAddr = Instruction[4:2];
            WriteSource  = {1'b1, Instruction[0]};
            RegWrEn      = 1'b1;
          end
          9'b100??????: begin
            WriteRegAddr = Instruction[5:3];
            ReadRegAddrB = Instruction[2:0];
            WriteSource  = 2'b01;
            if (LOAD_1CYC) begin
              RegWrEn = 1'b1;
            end else begin
              // Issue cycle: hold the PC while memory produces the data
              Stall       = 1'b1;
              ldr_issue_s = 1'b1;
            end
          end
          9'b101??????: begin
            ReadRegAddrA = Instruction[5:3];
            ReadRegAddrB = Instruction[2:0];
            MemWrEn      = 1'b1;
          end
          9'b1110?????: begin
            ReadRegAddrA = Instruction[4:2];
            ReadRegAddrB = {1'b1, Instruction[1:0]};
            ALUOp        = kXOR;
            cmp_s        = 1'b1;
          end
          9'b11110????: begin
            JumpTarget = TGT_W'(Instruction[3:0]);
            JumpTaken  = eq_flag_r;
          end
          // ACK shares the JNE prefix, so it must be matched first
          9'b111111111: begin
            ack_s = 1'b1;
          end
          9'b11111????: begin
            JumpTarget = TGT_W'(Instruction[3:0]);
            JumpTaken  = ~eq_flag_r;
          end
          default: begin
            Stall = 1'b0;
          end
        endcase
      end
      S_LOAD_WAIT: begin
        // PC is held, so Instruction still carries the LDR being serviced
        WriteRegAddr = Instruction[5:3];
        ReadRegAddrB = Instruction[2:0];
        WriteSource  = 2'b01;
        if (cnt_r == 3'd0) begin
          RegWrEn = 1'b1;
          Stall   = 1'b0;
        end else begin
          Stall = 1'b1;
        end
      end
      default: begin
        Stall = 1'b1;
      end
    endcase
  end

  // Sequencing state, equal flag, done flag and load-latency counter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r   <= S_IDLE;
      eq_flag_r <= 1'b0;
      done_r    <= 1'b0;
      cnt_r     <= 3'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (Start) begin
            state_r <= S_RUN;
          end
        end
        S_RUN: begin
          if (cmp_s) begin
            eq_flag_r <= Zero;
          end
          if (ack_s) begin
            state_r <= S_DONE;
            done_r  <= 1'b1;
          end else if (ldr_issue_s) begin
            state_r <= S_LOAD_WAIT;
            cnt_r   <= CNT_INIT;
          end
        end
        S_LOAD_WAIT: begin
          if (cnt_r == 3'd0) begin
            state_r <= S_RUN;
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        S_DONE: begin
          if (Start) begin
            state_r   <= S_RUN;
            done_r    <= 1'b0;
            eq_flag_r <= 1'b0;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
